// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types for the memory-access pipeline stage
package mem_access_stage_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        reg_write;
  } memwb_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic        overflow;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
  } exmem_t;

  // Every data access is a full word, so any nonzero low address bit is misaligned.
  function automatic logic word_misaligned(input logic [1:0] i_addr_lo);
    return i_addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_mux.sv
// rtl/mem_access_stage_mux.sv - two-input write-back select mux
module mux2 #(
  parameter int W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_access_stage_pipe_reg.sv
// rtl/mem_access_stage_pipe_reg.sv - pipeline register with load enable and sync active-low reset
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // clear on reset, otherwise capture whenever the stage advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM register, data-memory handshake and MEM/WB register
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_write_reg,
  input  logic              ex_overflow,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic              wb_valid,
  output logic [31:0]       wb_write_data,
  output logic [4:0]        wb_write_reg,
  output logic              wb_reg_write,
  output logic              exc_overflow,
  output logic              exc_misalign
);

  localparam int MEMWB_W = $bits(memwb_t) + 2;

  exmem_t               w_exmem_d;
  exmem_t               r_exmem;
  memwb_t               w_memwb_d;
  memwb_t               r_memwb;
  logic [1:0]           w_exc_d;
  logic [1:0]           r_exc;
  logic [MEMWB_W-1:0]   w_memwb_q;
  mem_state_t           r_state;
  mem_state_t           w_state_nxt;
  logic                 w_is_mem;
  logic                 w_misalign;
  logic                 w_need;
  logic                 w_req;
  logic                 w_load;
  logic                 w_rd_sel;
  logic [31:0]          w_wb_data;

  // EX/MEM next value; a flushed instruction enters as a bubble
  always_comb begin
    w_exmem_d            = '0;
    w_exmem_d.valid      = ex_valid & ~flush;
    w_exmem_d.alu_result = ex_alu_result;
    w_exmem_d.store_data = ex_store_data;
    w_exmem_d.write_reg  = ex_write_reg;
    w_exmem_d.overflow   = ex_overflow;
    w_exmem_d.mem_read   = ex_mem_read;
    w_exmem_d.mem_write  = ex_mem_write;
    w_exmem_d.mem_to_reg = ex_mem_to_reg;
    w_exmem_d.reg_write  = ex_reg_write;
  end

  // EX is frozen during a stall, so the register (and any flush) is ignored then
  assign w_load = ~mem_stall;

  pipe_reg #(.W($bits(exmem_t))) u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load),
    .i_d   (w_exmem_d),
    .o_q   (r_exmem)
  );

  assign w_is_mem   = r_exmem.mem_read | r_exmem.mem_write;
  assign w_misalign = CHECK_ALIGN && w_is_mem && word_misaligned(r_exmem.alu_result[1:0]);
  // overflow or misalignment kills the access so nothing is committed to memory
  assign w_need     = r_exmem.valid & w_is_mem & ~r_exmem.overflow & ~w_misalign;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a zero-wait access never leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_need && !dmem_ready) w_state_nxt = S_ACCESS;
      S_ACCESS: if (dmem_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output: request; reset gates it so an outstanding access drops at once
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_IDLE:   w_req = w_need;
      S_ACCESS: w_req = 1'b1;
      default:  w_req = 1'b0;
    endcase
    w_req = w_req & rst_n;
  end

  assign dmem_req   = w_req;
  assign mem_stall  = w_req & ~dmem_ready;
  assign dmem_we    = w_req & r_exmem.mem_write;
  assign dmem_addr  = r_exmem.alu_result[ADDR_W-1:0];
  assign dmem_wdata = r_exmem.store_data;

  // load data is only meaningful when an access actually completed
  assign w_rd_sel = r_exmem.mem_to_reg & w_need;

  mux2 #(.W(32)) u_wb_mux (
    .i_sel (w_rd_sel),
    .i_a   (r_exmem.alu_result),
    .i_b   (dmem_rdata),
    .o_y   (w_wb_data)
  );

  // MEM/WB next value: retire the held instruction, or push a bubble while stalled
  always_comb begin
    w_memwb_d           = r_memwb;
    w_memwb_d.valid     = 1'b0;
    w_memwb_d.reg_write = 1'b0;
    w_exc_d             = 2'b00;
    if (!mem_stall) begin
      w_memwb_d.valid      = r_exmem.valid;
      w_memwb_d.write_data = w_wb_data;
      w_memwb_d.write_reg  = r_exmem.write_reg;
      w_memwb_d.reg_write  = r_exmem.valid & r_exmem.reg_write & ~r_exmem.mem_write
                           & ~r_exmem.overflow & ~w_misalign;
      w_exc_d              = {r_exmem.valid & r_exmem.overflow, r_exmem.valid & w_misalign};
    end
  end

  pipe_reg #(.W(MEMWB_W)) u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (1'b1),
    .i_d   ({w_memwb_d, w_exc_d}),
    .o_q   (w_memwb_q)
  );

  assign r_memwb       = w_memwb_q[MEMWB_W-1:2];
  assign r_exc         = w_memwb_q[1:0];
  assign wb_valid      = r_memwb.valid;
  assign wb_write_data = r_memwb.write_data;
  assign wb_write_reg  = r_memwb.write_reg;
  assign wb_reg_write  = r_memwb.reg_write;
  assign exc_overflow  = r_exc[1];
  assign exc_misalign  = r_exc[0];

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_valid;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_overflow, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic [31:0] wb_write_data;
  logic [4:0]  wb_write_reg;
  logic        wb_reg_write, exc_overflow, exc_misalign;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_overflow(ex_overflow),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .wb_valid(wb_valid), .wb_write_data(wb_write_data),
    .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
    .exc_overflow(exc_overflow), .exc_misalign(exc_misalign)
  );

  typedef struct {
    bit          v;
    bit [31:0]   alu;
    bit [31:0]   sd;
    bit [4:0]    rd;
    bit          ov, mr, mw, m2r, rw;
    int unsigned wt;
  } ins_t;

  int n_cmp = 0, n_bad = 0;

  // reference model: instruction sitting in MEM, its remaining wait cycles, expected WB
  ins_t        cur;
  int          rem;
  bit          e_wv, e_rw, e_ov, e_mis;
  bit [31:0]   e_wd;
  bit [4:0]    e_wr;

  // directed-test observation
  int          req_cnt, hs_cnt, stall_cnt;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wd;
  bit          use_fix;
  bit [31:0]   rd_fix;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mis(input ins_t i);
    return (i.mr | i.mw) && (i.alu[1:0] != 2'b00);
  endfunction

  function automatic bit need(input ins_t i);
    return i.v && (i.mr | i.mw) && !i.ov && !mis(i);
  endfunction

  function automatic ins_t mk(input bit v, input bit [31:0] alu, input bit [31:0] sd,
                              input bit [4:0] rd, input bit ov, input bit mr, input bit mw,
                              input bit rw, input int unsigned wt);
    ins_t i;
    i.v = v; i.alu = alu; i.sd = sd; i.rd = rd; i.ov = ov;
    i.mr = mr; i.mw = mw; i.m2r = mr; i.rw = rw; i.wt = wt;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    int   k;
    i.v   = $urandom_range(99) < 85;
    i.alu = $urandom;
    if ($urandom_range(99) < 75) i.alu[1:0] = 2'b00;
    i.sd  = $urandom;
    i.rd  = 5'($urandom);
    i.ov  = $urandom_range(99) < 10;
    k     = $urandom_range(9);
    i.mr  = (k < 4) || (k == 9);
    i.mw  = (k >= 4 && k < 7) || (k == 9);
    i.m2r = i.mr;
    i.rw  = $urandom_range(99) < 80;
    i.wt  = $urandom_range(3);
    return i;
  endfunction

  // one clock: check outputs, drive EX and the memory responder, advance the model
  task automatic tick(input ins_t x, input bit fl, input bit rs, output bit acc);
    bit        xr, xs;
    bit [31:0] rdv;
    @(negedge clk);
    chk("wb_valid", wb_valid, e_wv);
    chk("wb_reg_write", wb_reg_write, e_rw);
    chk("exc_overflow", exc_overflow, e_ov);
    chk("exc_misalign", exc_misalign, e_mis);
    if (e_wv) chk("wb_write_reg", wb_write_reg, e_wr);
    if (e_rw) chk("wb_write_data", wb_write_data, e_wd);

    rst_n         = !rs;
    flush         = fl;
    ex_valid      = x.v;
    ex_alu_result = x.alu;
    ex_store_data = x.sd;
    ex_write_reg  = x.rd;
    ex_overflow   = x.ov;
    ex_mem_read   = x.mr;
    ex_mem_write  = x.mw;
    ex_mem_to_reg = x.m2r;
    ex_reg_write  = x.rw;

    xr  = !rs && need(cur);
    xs  = xr && (rem != 0);
    rdv = use_fix ? rd_fix : $urandom;
    dmem_rdata = rdv;
    dmem_ready = xr ? (rem == 0) : ($urandom_range(3) == 0);
    #1;
    chk("dmem_req", dmem_req, xr);
    chk("mem_stall", mem_stall, xs);
    if (xr) begin
      chk("dmem_we", dmem_we, cur.mw);
      chk("dmem_addr", dmem_addr, cur.alu);
      chk("dmem_wdata", dmem_wdata, cur.sd);
    end
    if (dmem_req) begin
      req_cnt++;
      cap_we = dmem_we; cap_addr = dmem_addr; cap_wd = dmem_wdata;
    end
    if (dmem_req && dmem_ready) hs_cnt++;
    if (mem_stall) stall_cnt++;

    acc = 1'b0;
    if (rs) begin
      cur.v = 1'b0; rem = 0;
      e_wv = 0; e_rw = 0; e_ov = 0; e_mis = 0; e_wd = '0; e_wr = '0;
    end else if (xs) begin
      rem--;
      e_wv = 0; e_rw = 0; e_ov = 0; e_mis = 0;
    end else begin
      e_wv  = cur.v;
      e_wr  = cur.rd;
      e_rw  = cur.v && cur.rw && !cur.ov && !mis(cur) && !cur.mw;
      e_wd  = (cur.m2r && xr) ? rdv : cur.alu;
      e_ov  = cur.v && cur.ov;
      e_mis = cur.v && mis(cur);
      cur   = x;
      cur.v = x.v && !fl;
      rem   = int'(x.wt);
      acc   = 1'b1;
    end
    @(posedge clk);
  endtask

  // present one instruction until MEM accepts it
  task automatic run(input ins_t x, input int flp, input int rprob);
    bit acc;
    int n = 0;
    do begin
      tick(x, $urandom_range(99) < flp, (rprob != 0) && ($urandom_range(99) < rprob), acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: not accepted after %0d cycles", n);
    end
  endtask

  task automatic clr_cnt();
    req_cnt = 0; hs_cnt = 0; stall_cnt = 0;
  endtask

  ins_t nop;
  ins_t t;
  bit   acc;

  initial begin
    rst_n = 0; flush = 0; ex_valid = 0; ex_alu_result = 0; ex_store_data = 0;
    ex_write_reg = 0; ex_overflow = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; ex_reg_write = 0; dmem_rdata = 0; dmem_ready = 0;
    use_fix = 0; rd_fix = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); rem = 0;
    e_wv = 0; e_rw = 0; e_ov = 0; e_mis = 0; e_wd = 0; e_wr = 0;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clr_cnt();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_write_data, 0);
    chk("rst_wb_reg", wb_write_reg, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_exc", {exc_overflow, exc_misalign}, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_addr", dmem_addr, 0);

    // ALU result write-back, no memory traffic
    clr_cnt();
    run(mk(1, 32'h10, 0, 8, 0, 0, 0, 1, 0), 0, 0);
    run(nop, 0, 0);
    #2;
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_data", wb_write_data, 32'h10);
    chk("add_wb_reg", wb_write_reg, 8);
    chk("add_wb_reg_write", wb_reg_write, 1);
    chk("add_req_count", req_cnt, 0);

    // load with three wait cycles
    use_fix = 1; rd_fix = 32'hDEADBEEF;
    clr_cnt();
    run(mk(1, 32'h100, 0, 5, 0, 1, 0, 1, 3), 0, 0);
    run(nop, 0, 0);
    #2;
    chk("load_stall_cycles", stall_cnt, 3);
    chk("load_handshakes", hs_cnt, 1);
    chk("load_wb_data", wb_write_data, 32'hDEADBEEF);
    chk("load_wb_reg_write", wb_reg_write, 1);
    use_fix = 0;

    // zero-wait store
    clr_cnt();
    run(mk(1, 32'h204, 32'h1234, 3, 0, 0, 1, 1, 0), 0, 0);
    run(nop, 0, 0);
    #2;
    chk("store_req_count", req_cnt, 1);
    chk("store_we", cap_we, 1);
    chk("store_addr", cap_addr, 32'h204);
    chk("store_wdata", cap_wd, 32'h1234);
    chk("store_stall", stall_cnt, 0);
    chk("store_wb_reg_write", wb_reg_write, 0);

    // misaligned load
    clr_cnt();
    run(mk(1, 32'h102, 0, 6, 0, 1, 0, 1, 0), 0, 0);
    run(nop, 0, 0);
    #2;
    chk("mis_req_count", req_cnt, 0);
    chk("mis_exc", exc_misalign, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_reg_write", wb_reg_write, 0);

    // overflowing add, then overflowing store
    run(mk(1, 32'h8000_0000, 0, 9, 1, 0, 0, 1, 0), 0, 0);
    run(nop, 0, 0);
    #2;
    chk("ovf_exc", exc_overflow, 1);
    chk("ovf_wb_reg_write", wb_reg_write, 0);
    clr_cnt();
    run(mk(1, 32'h300, 32'h55, 0, 1, 0, 1, 0, 0), 0, 0);
    run(nop, 0, 0);
    #2;
    chk("ovf_store_req_count", req_cnt, 0);
    chk("ovf_store_exc", exc_overflow, 1);

    // reset while a load is waiting
    run(mk(1, 32'h400, 0, 7, 0, 1, 0, 1, 3), 0, 0);
    tick(nop, 0, 0, acc);
    tick(nop, 0, 0, acc);
    tick(nop, 0, 1, acc);
    #2;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    run(nop, 0, 0);

    // flushed instruction becomes a bubble
    run(mk(1, 32'h44, 0, 4, 0, 0, 0, 1, 0), 100, 0);
    run(nop, 0, 0);
    #2;
    chk("flush_wb_valid", wb_valid, 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      t = rnd();
      run(t, 10, 2);
    end
    repeat (6) run(nop, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the Execution stage: holds the EX/MEM pipeline register and performs loads and stores on the data memory.
- The data memory uses a variable-latency req/ready handshake.
- Produces the MEM/WB register (write-back value, destination register, write enable) and back-pressures upstream with mem_stall while an access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width (low ADDR_W bits of ALU result).
- CHECK_ALIGN, 1, when 1 a word access with addr[1:0]!=0 raises misalign and issues no request.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  kill instruction being captured this cycle (bubble)
- ex_valid  input  1  EX stage presents a valid instruction
- ex_alu_result  input  32  ALU result; memory address for load/store
- ex_store_data  input  32  rt operand (store data)
- ex_write_reg  input  5  destination register from RegDst mux
- ex_overflow  input  1  ALU overflow
- ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  input  1 each  control
- mem_stall  output  1  upstream must hold; EX/MEM register not loading
- dmem_req  output  1  access request
- dmem_we  output  1  1=store, 0=load
- dmem_addr  output  ADDR_W  byte address
- dmem_wdata  output  32  store data
- dmem_rdata  input  32  load data, valid with dmem_ready
- dmem_ready  input  1  access complete this cycle
- wb_valid  output  1  MEM/WB holds valid instruction
- wb_write_data  output  32  load data or ALU result
- wb_write_reg  output  5  destination register
- wb_reg_write  output  1  register-file write enable
- exc_overflow, exc_misalign  output  1 each  exception, one-cycle pulse aligned with wb_valid

Behaviour:
- Reset (rst_n=0 at clk edge):
  - EX/MEM and MEM/WB valid cleared; FSM to IDLE.
  - All outputs 0, including dmem_req, mem_stall and wb_* data.
- EX/MEM capture:
  - Loads ex_* fields when mem_stall=0.
  - Valid bit = ex_valid & ~flush.
  - Fields are held unchanged while mem_stall=1; flush during stall is ignored, since EX is held.
- FSM states:
  - IDLE: no outstanding access.
  - ACCESS: request outstanding.
- IDLE behaviour:
  - If the held instruction is valid, (mem_read|mem_write), not misaligned, and not already serviced: assert dmem_req combinationally and go to ACCESS.
  - If dmem_ready=1 in that same cycle, the access completes with zero wait and the FSM stays in IDLE.
- ACCESS behaviour:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata are stable from the EX/MEM register.
  - Return to IDLE on dmem_ready.
- mem_stall = dmem_req & ~dmem_ready.
- dmem_req deasserts the cycle after ready; each instruction issues exactly one request.
- MEM/WB update, when mem_stall=0:
  - wb_valid <= EX/MEM valid.
  - wb_write_data <= mem_to_reg ? dmem_rdata (sampled at ready) : alu_result.
  - wb_write_reg <= write_reg.
  - wb_reg_write <= reg_write & valid & ~overflow & ~misalign.
- MEM/WB hold, when mem_stall=1:
  - wb_valid <= 0 (bubble into WB); wb_reg_write <= 0.
- Latency:
  - Non-memory instruction: 1 cycle EX/MEM to MEM/WB.
  - Memory instruction: 1 cycle + wait cycles (cycles with req & ~ready).
- Overflow:
  - Suppresses write-back and pulses exc_overflow.
  - Overflow on a memory instruction also suppresses the request: no store is committed.
- Misalign (CHECK_ALIGN=1):
  - No request; pulses exc_misalign; reg write suppressed.
- Store (mem_write=1): wb_reg_write=0 regardless of reg_write.
- mem_read and mem_write both 1 is illegal; treat as a store.
- Reset mid-access:
  - FSM returns to IDLE; dmem_req drops immediately; the pending instruction is discarded.
- dmem_ready while dmem_req=0 is ignored.

Decomposition:
- Shared package: FSM state enum (IDLE, ACCESS) and a MEM/WB bundle typedef (valid, write_data, write_reg, reg_write).
- Keep the existing MUX module for the write-back select.
- Natural sub-module: pipe_reg, a parameterised-width register with synchronous active-low reset and load enable, used for both the EX/MEM and MEM/WB registers.

Test Plan:
- Add result 0x0000_0010, write_reg=8, reg_write=1, non-memory -> next cycle wb_valid=1, wb_write_data=0x10, wb_write_reg=8, wb_reg_write=1; dmem_req never asserted.
- Load, addr 0x100, ready 3 cycles after req, rdata=0xDEADBEEF -> mem_stall high exactly 3 cycles; one request; then wb_write_data=0xDEADBEEF, wb_reg_write=1.
- Store, addr 0x204, data 0x1234, ready same cycle -> dmem_we=1, addr 0x204, wdata 0x1234 for one cycle; mem_stall never high; wb_reg_write=0.
- Load addr 0x102 -> no dmem_req; exc_misalign pulses with wb_valid; wb_reg_write=0.
- ex_overflow=1 on add with reg_write=1 -> exc_overflow pulse; wb_reg_write=0; same with store -> no dmem_req.
- rst_n low during ACCESS wait -> next cycle dmem_req=0, mem_stall=0, wb_valid=0; flush with ex_valid=1 -> bubble, wb_valid=0.
